// File: rtl/calc_req_issuer_if.sv
// Host/calculator-facing signal bundle for calc_req_issuer.
// slave = issuer's view, master = the surrounding host + calculator port.
interface calc_req_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [3:0]  calc_cmd;
    logic [31:0] calc_data;
    logic [1:0]  calc_tag;
    logic [1:0]  calc_resp;
    logic [31:0] calc_out_data;
    logic [1:0]  calc_out_tag;
    logic        cpl_valid;
    logic [1:0]  cpl_resp;
    logic [31:0] cpl_data;
    logic [1:0]  cpl_tag;
    logic        busy;
    logic        spurious_err;

    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2,
               calc_resp, calc_out_data, calc_out_tag,
        output req_ready, calc_cmd, calc_data, calc_tag,
               cpl_valid, cpl_resp, cpl_data, cpl_tag, busy, spurious_err
    );

    modport master (
        output req_valid, req_cmd, req_op1, req_op2,
               calc_resp, calc_out_data, calc_out_tag,
        input  req_ready, calc_cmd, calc_data, calc_tag,
               cpl_valid, cpl_resp, cpl_data, cpl_tag, busy, spurious_err
    );
endinterface

// File: rtl/calc_req_issuer.sv
// Per-port request issuer: FIFO-buffers host requests, allocates 2-bit tags, drives the
// two-cycle calculator command protocol and returns completions. Optional per-tag
// response watchdog enabled by defining CALC_ISSUER_TIMEOUT_EN.
module calc_req_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               c_clk,
    input  logic               reset,
    calc_req_issuer_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, OP1, OP2} state_t;

    state_t      state_reg;
    logic [3:0]  cmd_mem [FIFO_DEPTH];
    logic [31:0] op1_mem [FIFO_DEPTH];
    logic [31:0] op2_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic        req_ready_reg;

    logic [3:0]  cur_cmd_reg;
    logic [31:0] cur_op1_reg, cur_op2_reg;
    logic [1:0]  cur_tag_reg;

    logic [3:0]  inflight_reg, inflight_next;
    logic [3:0]  calc_cmd_reg;
    logic [31:0] calc_data_reg;
    logic [1:0]  calc_tag_reg;
    logic        cpl_valid_reg;
    logic [1:0]  cpl_resp_reg;
    logic [31:0] cpl_data_reg;
    logic [1:0]  cpl_tag_reg;
    logic        spurious_reg;

    logic        push, pop, eligible;
    logic [1:0]  alloc_tag;
    logic        resp_hit, resp_spur;
    logic        to_fire;
    logic [1:0]  to_tag;

    assign push      = bus.req_valid && req_ready_reg;
    assign eligible  = (count_reg != '0) && (inflight_reg != 4'hF);
    assign pop       = eligible && ((state_reg == IDLE) || (state_reg == OP2));
    assign resp_hit  = (bus.calc_resp != 2'd0) && inflight_reg[bus.calc_out_tag];
    assign resp_spur = (bus.calc_resp != 2'd0) && !inflight_reg[bus.calc_out_tag];

    // Lowest-index free tag; only meaningful when eligible.
    always_comb begin
        alloc_tag = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!inflight_reg[i]) alloc_tag = 2'(i);
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (!push && pop)
            count_next = count_reg - 1'b1;
    end

    // Freed tags only become visible to allocation through the register: no bypass.
    always_comb begin
        inflight_next = inflight_reg;
        if (resp_hit) inflight_next[bus.calc_out_tag] = 1'b0;
        if (to_fire)  inflight_next[to_tag] = 1'b0;
        if (pop)      inflight_next[alloc_tag] = 1'b1;
    end

`ifdef CALC_ISSUER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [3:0] expired;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wd
            logic [TW-1:0] cnt_reg;
            always_ff @(posedge c_clk or posedge reset) begin
                if (reset)
                    cnt_reg <= '0;
                else if (pop && (alloc_tag == 2'(gi)))
                    cnt_reg <= '0;
                else if (inflight_reg[gi] && !expired[gi])
                    cnt_reg <= cnt_reg + 1'b1;
            end
            assign expired[gi] = inflight_reg[gi] && (cnt_reg == TW'(TIMEOUT));
        end
    endgenerate

    // A real response owns the completion slot; expired tags wait a cycle.
    always_comb begin
        to_fire = !resp_hit && (expired != 4'd0);
        to_tag  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (expired[i]) to_tag = 2'(i);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign to_fire = 1'b0;
    assign to_tag  = 2'd0;
`endif

    // Storage and popped-entry capture kept reset-free so the arrays map to RAM.
    always_ff @(posedge c_clk) begin
        if (push) begin
            cmd_mem[wr_ptr_reg] <= bus.req_cmd;
            op1_mem[wr_ptr_reg] <= bus.req_op1;
            op2_mem[wr_ptr_reg] <= bus.req_op2;
        end
        if (pop) begin
            cur_cmd_reg <= cmd_mem[rd_ptr_reg];
            cur_op1_reg <= op1_mem[rd_ptr_reg];
            cur_op2_reg <= op2_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            req_ready_reg <= 1'b0;
            cur_tag_reg   <= 2'd0;
            inflight_reg  <= 4'd0;
            calc_cmd_reg  <= 4'd0;
            calc_data_reg <= 32'd0;
            calc_tag_reg  <= 2'd0;
            cpl_valid_reg <= 1'b0;
            cpl_resp_reg  <= 2'd0;
            cpl_data_reg  <= 32'd0;
            cpl_tag_reg   <= 2'd0;
            spurious_reg  <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                cur_tag_reg <= alloc_tag;
            end
            count_reg     <= count_next;
            req_ready_reg <= (count_next != CW'(FIFO_DEPTH));
            inflight_reg  <= inflight_next;

            // Bus outputs reflect the state held during the previous cycle.
            case (state_reg)
                OP1: begin
                    calc_cmd_reg  <= cur_cmd_reg;
                    calc_data_reg <= cur_op1_reg;
                    calc_tag_reg  <= cur_tag_reg;
                    state_reg     <= OP2;
                end
                OP2: begin
                    calc_cmd_reg  <= 4'd0;
                    calc_data_reg <= cur_op2_reg;
                    calc_tag_reg  <= cur_tag_reg;
                    state_reg     <= pop ? OP1 : IDLE;
                end
                default: begin
                    calc_cmd_reg  <= 4'd0;
                    calc_data_reg <= 32'd0;
                    calc_tag_reg  <= 2'd0;
                    state_reg     <= pop ? OP1 : IDLE;
                end
            endcase

            cpl_valid_reg <= resp_hit || to_fire;
            if (resp_hit) begin
                cpl_resp_reg <= bus.calc_resp;
                cpl_data_reg <= bus.calc_out_data;
                cpl_tag_reg  <= bus.calc_out_tag;
            end else if (to_fire) begin
                cpl_resp_reg <= 2'd3;
                cpl_data_reg <= 32'd0;
                cpl_tag_reg  <= to_tag;
            end
            if (resp_spur) spurious_reg <= 1'b1;
        end
    end

    assign bus.req_ready    = req_ready_reg;
    assign bus.calc_cmd     = calc_cmd_reg;
    assign bus.calc_data    = calc_data_reg;
    assign bus.calc_tag     = calc_tag_reg;
    assign bus.cpl_valid    = cpl_valid_reg;
    assign bus.cpl_resp     = cpl_resp_reg;
    assign bus.cpl_data     = cpl_data_reg;
    assign bus.cpl_tag      = cpl_tag_reg;
    assign bus.spurious_err = spurious_reg;
    assign bus.busy         = (count_reg != '0) || (state_reg != IDLE) || (inflight_reg != 4'd0);
endmodule

// File: tb/tb_calc_req_issuer.sv
// Directed self-checking bench for calc_req_issuer (timeout case runs only when
// CALC_ISSUER_TIMEOUT_EN is defined).
module tb_calc_req_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    calc_req_issuer_if bus();

`ifdef CALC_ISSUER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    calc_req_issuer #(.FIFO_DEPTH(4), .TIMEOUT(TB_TIMEOUT)) dut (
        .c_clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] calc_now, cpl_now;
    assign calc_now = {26'd0, bus.calc_cmd, bus.calc_data, bus.calc_tag};
    assign cpl_now  = {27'd0, bus.cpl_valid, bus.cpl_resp, bus.cpl_data, bus.cpl_tag};

    function automatic logic [63:0] cv(input int c, input int d, input int t);
        return {26'd0, c[3:0], d[31:0], t[1:0]};
    endfunction

    function automatic logic [63:0] cp(input int v, input int r, input int d, input int t);
        return {27'd0, v[0], r[1:0], d[31:0], t[1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic respond(input int r, input int d, input int t);
        bus.calc_resp     = r[1:0];
        bus.calc_out_data = d[31:0];
        bus.calc_out_tag  = t[1:0];
        tick();
        bus.calc_resp     = 2'd0;
        bus.calc_out_data = 32'd0;
        bus.calc_out_tag  = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int j;
        int cycles;
        bus.req_valid     = 1'b0;
        bus.req_cmd       = 4'd0;
        bus.req_op1       = 32'd0;
        bus.req_op2       = 32'd0;
        bus.calc_resp     = 2'd0;
        bus.calc_out_data = 32'd0;
        bus.calc_out_tag  = 2'd0;

        // Reset and idle
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_calc",  calc_now, 64'd0);
        check("rst_cpl",   cpl_now, 64'd0);
        check("rst_busy",  64'(bus.busy), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", 64'(bus.req_ready), 64'd1);
        check("idle_busy",  64'(bus.busy), 64'd0);
        check("idle_spur",  64'(bus.spurious_err), 64'd0);

        // Single request 1/5/7
        bus.req_valid = 1'b1; bus.req_cmd = 4'd1; bus.req_op1 = 32'd5; bus.req_op2 = 32'd7;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("single_e1", calc_now, cv(0, 0, 0));
        tick();
        check("single_op1", calc_now, cv(1, 5, 0));
        tick();
        check("single_op2", calc_now, cv(0, 7, 0));
        tick();
        check("single_idle", calc_now, cv(0, 0, 0));
        check("single_busy", 64'(bus.busy), 64'd1);
        respond(1, 12, 0);
        check("single_cpl", cpl_now, cp(1, 1, 12, 0));
        tick();
        check("single_cpl_end", 64'(bus.cpl_valid), 64'd0);
        check("single_busy_end", 64'(bus.busy), 64'd0);

        // Spurious response on a free tag
        respond(2, 99, 3);
        check("spur_nocpl", 64'(bus.cpl_valid), 64'd0);
        check("spur_flag", 64'(bus.spurious_err), 64'd1);
        tick();
        check("spur_sticky", 64'(bus.spurious_err), 64'd1);

        // Six requests, no responses: tags 0..3 back-to-back then stall
        bus.req_valid = 1'b1; bus.req_cmd = 4'd2; bus.req_op1 = 32'd100; bus.req_op2 = 32'd200;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k < 6) begin
                bus.req_cmd = 4'(k + 2);
                bus.req_op1 = 32'(100 + k);
                bus.req_op2 = 32'(200 + k);
            end else begin
                bus.req_valid = 1'b0;
            end
            if (k >= 3 && k <= 10) begin
                j = (k - 3) / 2;
                if (((k - 3) % 2) == 0)
                    check($sformatf("b2b_e%0d", k), calc_now, cv(j + 2, 100 + j, j));
                else
                    check($sformatf("b2b_e%0d", k), calc_now, cv(0, 200 + j, j));
            end else begin
                check($sformatf("b2b_e%0d", k), calc_now, cv(0, 0, 0));
            end
            check($sformatf("b2b_ready%0d", k), 64'(bus.req_ready), 64'd1);
        end
        tick();
        tick();
        check("stall_calc", calc_now, cv(0, 0, 0));
        check("stall_busy", 64'(bus.busy), 64'd1);

        // Release tag 2: reissued to the fifth request
        respond(1, 32'h55, 2);
        check("rel_cpl", cpl_now, cp(1, 1, 32'h55, 2));
        tick();
        check("reiss_wait", calc_now, cv(0, 0, 0));
        tick();
        check("reiss_op1", calc_now, cv(6, 104, 2));
        tick();
        check("reiss_op2", calc_now, cv(0, 204, 2));

        // Reset while OP2 is on the bus
        rst = 1'b1;
        #1;
        check("mrst_calc",  calc_now, 64'd0);
        check("mrst_cpl",   cpl_now, 64'd0);
        check("mrst_ready", 64'(bus.req_ready), 64'd0);
        check("mrst_spur",  64'(bus.spurious_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("mrst_ready_after", 64'(bus.req_ready), 64'd1);
        respond(1, 77, 2);
        check("mrst_resp_spur", 64'(bus.spurious_err), 64'd1);
        check("mrst_resp_nocpl", 64'(bus.cpl_valid), 64'd0);
        check("mrst_busy", 64'(bus.busy), 64'd0);

`ifdef CALC_ISSUER_TIMEOUT_EN
        // Withheld response: watchdog completion then tag reuse
        bus.req_valid = 1'b1; bus.req_cmd = 4'd4; bus.req_op1 = 32'd1; bus.req_op2 = 32'd2;
        tick();
        bus.req_valid = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            cycles = i;
            if (bus.cpl_valid) break;
        end
        check("to_cycles", 64'(cycles), 64'd12);
        check("to_cpl", cpl_now, cp(1, 3, 0, 0));
        bus.req_valid = 1'b1; bus.req_cmd = 4'd3; bus.req_op1 = 32'd9; bus.req_op2 = 32'd8;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("to_reuse", calc_now, cv(3, 9, 0));
`else
        cycles = 0;
        j = cycles;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/calc_req_issuer.md
# calc_req_issuer

Per-port request issuer that sits directly upstream of one `calc2_top` request/response port pair. It accepts complete two-operand requests from a host over a valid/ready handshake and buffers them in a small FIFO. It allocates a free 2-bit tag and drives the calculator's two-cycle command protocol. It matches calculator responses back to their tags, releases the tags, and hands completions to the host. Four instances, one per port, feed `req1..req4_*` and consume `out_*1..4`.

## Interface
- `FIFO_DEPTH`, default 4: request FIFO entries; power of two, 2..16.
- `TIMEOUT`, default 255: response watchdog limit in cycles. Used only with `CALC_ISSUER_TIMEOUT_EN`.
- `c_clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  host request valid.
- `req_ready`  out  1  FIFO can accept a request.
- `req_cmd`  in  4  calculator command, passed through unchecked.
- `req_op1` / `req_op2`  in  32 each  first and second operand.
- `calc_cmd`  out  4  to `reqN_cmd_in`.
- `calc_data`  out  32  to `reqN_data_in`.
- `calc_tag`  out  2  to `reqN_tag_in`.
- `calc_resp`  in  2  from `out_respN`; 0 = none.
- `calc_out_data`  in  32  from `out_dataN`.
- `calc_out_tag`  in  2  from `out_tagN`.
- `cpl_valid`  out  1  one-cycle completion pulse.
- `cpl_resp` / `cpl_data` / `cpl_tag`  out  2/32/2  completion contents.
- `busy`  out  1  FIFO non-empty, issue in progress, or any tag in flight.
- `spurious_err`  out  1  sticky; a response arrived for a tag not in flight.

## Operation
- FIFO:
  - Push on `req_valid && req_ready`; `req_ready = !full`, derived from the registered count.
  - Push while full is impossible by construction. Push and pop in the same cycle leave the count unchanged.
- Tag table: 4 in-flight bits. The lowest-index free tag is allocated.
- Issue FSM states:
  - IDLE: if the FIFO is non-empty and any tag is free, pop the FIFO, latch the allocated tag, set its in-flight bit, and go to OP1.
  - OP1: drive `calc_cmd=req_cmd`, `calc_data=op1`, `calc_tag=tag`; go to OP2.
  - OP2: drive `calc_cmd=0`, `calc_data=op2`, `calc_tag=tag`. If a new request is eligible, pop it and go straight to OP1 (back-to-back). Otherwise go to IDLE.
  - In IDLE, all `calc_*` outputs are driven 0.
- Response path:
  - When `calc_resp!=0` and the tag is in flight: clear the in-flight bit; next cycle pulse `cpl_valid=1` with registered `cpl_resp/cpl_data/cpl_tag`.
  - When `calc_resp!=0` and the tag is not in flight: set `spurious_err`; no completion is produced.
- Simultaneous release and allocation: a tag freed in cycle N is allocatable from cycle N+1. There is no same-cycle bypass.
- All four tags busy: the FSM holds in IDLE. The FIFO keeps accepting until full.
- Reset values: all outputs 0 (`req_ready` is 0 during reset, 1 after), FIFO empty, tag table clear, FSM in IDLE.
- Reset mid-operation: in-flight requests are discarded and no completions are emitted for them.

## Timing
- Acceptance edge E: the OP1 values appear on `calc_*` after edge E+2 (1 cycle FIFO write, 1 cycle IDLE decision). OP2 values follow after E+3.
- Sustained throughput: one request per 2 cycles while tags are available.
- Completion: `cpl_valid` is asserted exactly 1 cycle after the cycle in which `calc_resp!=0` is sampled.
- `cpl_valid` has no backpressure; the host must sample it every cycle.

## Configuration
- `CALC_ISSUER_TIMEOUT_EN` defined:
  - Each tag has an 8-bit-or-wider watchdog counter that starts at allocation.
  - When a counter reaches `TIMEOUT` with no response, the tag is freed and a completion is emitted with `cpl_resp=3`, `cpl_data=0`, and that tag.
  - A later response for that tag counts as spurious.
  - If a timeout and a real response collide in the same cycle, the real response wins.
- Undefined: no counters; tags wait indefinitely.

## Test plan
- Reset then idle: all outputs 0, `req_ready=1`, `busy=0`.
- Push cmd=1, op1=5, op2=7:
  - `calc_cmd/data/tag` read 1/5/0, then 0/7/0.
  - Respond resp=1, data=12, tag=0 → one `cpl_valid` pulse with 1/12/0; `busy` drops.
- Push 6 requests with no responses:
  - Tags 0,1,2,3 are issued back-to-back, then issue stalls.
  - The FIFO holds 2; with `FIFO_DEPTH=4` `req_ready` stays 1.
  - Respond tag 2 → tag 2 reissued to the 5th request 1 cycle later.
- Respond resp=2 on tag 3 while it is not in flight → `spurious_err=1` sticky, no `cpl_valid`.
- Assert reset during OP2 of a request → outputs 0 immediately; after reset, a response for that tag sets `spurious_err`.
- With `CALC_ISSUER_TIMEOUT_EN` and `TIMEOUT=10`: issue one request, withhold the response → `cpl_resp=3` on tag 0 after 10 cycles, and the tag is reusable.
